exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter: VECTOR, 64'h0000_0000_0000_00D8, exception handler entry address.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- ExtIRQ  in  1  raw external interrupt request, level, held until acknowledged.
- EStatus  in  4  decoder cause: 0000 none, 0001 IRQ, 0010 invalid opcode.
- ERet  in  1  decoder flags ERET in current instruction.
- PC  in  64  address of current instruction.
- IRQ  out  1  masked, registered interrupt request fed to decoder ExtIRQ input.
- ExtIAck  out  1  one-cycle acknowledge to interrupting device.
- Exc  out  1  redirect PC to ExcVector this cycle.
- ExcVector  out  64  equals VECTOR.
- ELR  out  64  exception link register.
- ESR  out  64  exception syndrome, EStatus zero-extended.
- EProc  out  1  high while in HANDLER state.

Function
REQ-003 SHALL implement FSM states RUN and HANDLER; EProc = (state == HANDLER).
REQ-004 SHALL drive Exc combinationally: high when EStatus != 0000 and (state == RUN or EStatus == 0010).
REQ-005 SHALL, on edge with Exc high in RUN: ESR <= zero-extended EStatus; ELR <= PC+4 for 0001, PC for 0010; state <= HANDLER.
REQ-006 SHALL, on nested fault (HANDLER, EStatus 0010): update ESR to 0010, leave ELR unchanged, stay HANDLER.
REQ-007 SHALL, on edge with ERet high in HANDLER and Exc low, return to RUN; ERet in RUN SHALL not change state.
REQ-008 SHALL give Exc priority over ERet when both occur in the same cycle.
REQ-009 SHALL assert ExtIAck for exactly one cycle, the cycle after an IRQ-cause capture.
REQ-010 SHALL drive IRQ = irq_q AND (state == RUN) AND NOT ExtIAck, where irq_q is the registered ExtIRQ.
REQ-011 SHALL keep ExtIRQ masked throughout HANDLER; a still-pending request SHALL reappear on IRQ the first RUN cycle after ERET.
REQ-012 SHALL perform PC+4 as 64-bit modulo addition; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-013 SHALL ignore reserved EStatus codes (0011..1111): Exc low, no state change.

Reset
REQ-014 SHALL, on reset assertion, immediately force state RUN, ELR 0, ESR 0, ExtIAck 0, IRQ 0, synchronizer flops 0.
REQ-015 SHALL cancel any in-progress handler or pending ack on mid-operation reset; no ExtIAck after release.

Configuration
REQ-016 SHALL honour macro EXTIRQ_SYNC_EN:
- defined: ExtIRQ passes a two-flop synchronizer before irq_q; ExtIRQ-to-IRQ latency 2 cycles.
- undefined: single register stage; latency 1 cycle.

Structure
REQ-017 SHALL place EStatus codes, the FSM state enum and the default VECTOR in shared package exc_pkg.
REQ-018 SHALL instantiate one sub-module, sync2, for the EXTIRQ_SYNC_EN synchronizer.

Verification
REQ-019 Bench SHALL cover:
- Invalid opcode: PC=0x40, EStatus=0010 -> Exc=1 same cycle; next edge ELR=0x40, ESR=2, EProc=1, ExtIAck stays 0.
- IRQ: ExtIRQ=1 -> IRQ=1 after 1 cycle (2 with EXTIRQ_SYNC_EN); EStatus=0001, PC=0x100 -> ELR=0x104, ESR=1, ExtIAck one cycle, then IRQ=0.
- Masking and return: ExtIRQ held during HANDLER -> IRQ=0; ERet=1 -> RUN next edge, IRQ=1 the following cycle.
- Nested fault: in HANDLER with ELR=0x104, EStatus=0010, PC=0xD8 -> Exc=1, ESR=2, ELR=0x104, EProc=1.
- Simultaneous ERet and EStatus=0010 in HANDLER -> stays HANDLER, ESR=2.
- Reset mid-handler: reset pulse in HANDLER -> EProc=0, ELR=0, ESR=0 immediately; no ExtIAck after release.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: decoder cause codes, FSM states and
// the default handler entry address.
package exc_pkg;

  localparam logic [3:0] EsNone  = 4'b0000;
  localparam logic [3:0] EsIrq   = 4'b0001;
  localparam logic [3:0] EsInvOp = 4'b0010;

  typedef enum logic {
    StRun,
    StHandler
  } exc_state_e;

  localparam logic [63:0] DefaultVector = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Asynchronous active-high reset clears both stages.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: captures faults/interrupts, holds ELR/ESR, masks IRQ while handling.
// Build option EXTIRQ_SYNC_EN routes ExtIRQ through a two-flop synchronizer (sync2).
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [63:0] VECTOR = DefaultVector
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExtIRQ,
  input  logic [3:0]  EStatus,
  input  logic        ERet,
  input  logic [63:0] PC,
  output logic        IRQ,
  output logic        ExtIAck,
  output logic        Exc,
  output logic [63:0] ExcVector,
  output logic [63:0] ELR,
  output logic [63:0] ESR,
  output logic        EProc
);

  exc_state_e  state_q, state_d;
  logic [63:0] elr_q, elr_d;
  logic [3:0]  esr_q, esr_d;
  logic        ack_q, ack_d;
  logic        irq_q;
  logic        in_run;

`ifdef EXTIRQ_SYNC_EN
  // The synchronizer's second stage serves directly as irq_q (two-cycle latency).
  sync2 u_sync2 (
    .clk  (clk),
    .reset(reset),
    .d    (ExtIRQ),
    .q    (irq_q)
  );
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ExtIRQ;
    end
  end
`endif

  assign in_run = (state_q == StRun);

  // Only an invalid opcode may fault inside the handler; reserved codes never raise Exc.
  assign Exc = ((EStatus == EsIrq) && in_run) || (EStatus == EsInvOp);

  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
    ack_d   = 1'b0;
    if (Exc) begin
      esr_d = EStatus;
      if (in_run) begin
        state_d = StHandler;
        elr_d   = (EStatus == EsIrq) ? PC + 64'd4 : PC;
        ack_d   = (EStatus == EsIrq);
      end
    end else if (ERet && !in_run) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      elr_q   <= 64'd0;
      esr_q   <= 4'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
      ack_q   <= ack_d;
    end
  end

  assign IRQ       = irq_q && in_run && !ack_q;
  assign ExtIAck   = ack_q;
  assign ExcVector = VECTOR;
  assign ELR       = elr_q;
  assign ESR       = {60'd0, esr_q};
  assign EProc     = (state_q == StHandler);

endmodule
